// File: rtl/w5300_init_sequencer.sv
// W5300 post-reset configuration sequencer: pulses the chip reset, checks the chip ID, programs
// network identity and memory split, then opens socket 0 in UDP mode over the req/ack register port.
module w5300_init_sequencer #(
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter int unsigned RST_HOLD_US  = 2,
  parameter int unsigned RST_WAIT_MS  = 10,
  parameter logic [15:0] TMS01R_VAL   = 16'h2020,
  parameter logic [15:0] RMS01R_VAL   = 16'h2020,
  parameter logic [15:0] MTYPER_VAL   = 16'h00FF,
  parameter logic [15:0] SRC_PORT     = 16'd5000,
  parameter int unsigned POLL_LIMIT   = 1024,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [47:0] mac_i,
  input  logic [31:0] ipv4_i,
  input  logic [31:0] subnet_i,
  output logic        w5300_rst_n_o,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [9:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o,
  input  logic        reg_ack_i,
  input  logic [15:0] reg_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  error_code_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HW_RST   = 3'd1;
  localparam logic [2:0] S_HW_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  localparam logic [31:0] HOLD_CYC = 32'(CLK_FREQ_MHZ * RST_HOLD_US);
  localparam logic [31:0] WAIT_CYC = 32'(CLK_FREQ_MHZ * 1000 * RST_WAIT_MS);
  localparam logic [15:0] POLL_MAX = 16'(POLL_LIMIT);
  localparam logic [15:0] ACK_MAX  = 16'(ACK_TIMEOUT);

  localparam logic [4:0] STEP_IDR = 5'd0;
  localparam logic [4:0] STEP_SSR = 5'd16;

  localparam logic [1:0] ERR_ID   = 2'd1;
  localparam logic [1:0] ERR_POLL = 2'd2;
  localparam logic [1:0] ERR_ACK  = 2'd3;

  logic [2:0]  r_state;
  logic [31:0] r_cnt;
  logic [15:0] r_ack_cnt;
  logic [15:0] r_poll_cnt;
  logic [4:0]  r_step;
  logic [47:0] r_mac;
  logic [31:0] r_ipv4;
  logic [31:0] r_subnet;
  logic [23:0] r_gw_hi;
  logic [1:0]  r_err_code;

  logic        w_req;
  logic        w_ack;
  logic        w_we;
  logic [9:0]  w_addr;
  logic [15:0] w_wdata;

  // The request is decoded from state so it drops on the very edge that leaves WAIT_ACK or applies rst.
  assign w_req = (r_state == S_ISSUE) || (r_state == S_WAIT_ACK);
  assign w_ack = w_req && reg_ack_i;

  always_comb begin
    w_we    = 1'b1;
    w_addr  = 10'h000;
    w_wdata = 16'h0000;
    case (r_step)
      5'd0:  begin w_we = 1'b0; w_addr = 10'h0FE; end
      5'd1:  begin w_addr = 10'h008; w_wdata = r_mac[47:32]; end
      5'd2:  begin w_addr = 10'h00A; w_wdata = r_mac[31:16]; end
      5'd3:  begin w_addr = 10'h00C; w_wdata = r_mac[15:0]; end
      5'd4:  begin w_addr = 10'h010; w_wdata = r_gw_hi[23:8]; end
      5'd5:  begin w_addr = 10'h012; w_wdata = {r_gw_hi[7:0], 8'h01}; end
      5'd6:  begin w_addr = 10'h014; w_wdata = r_subnet[31:16]; end
      5'd7:  begin w_addr = 10'h016; w_wdata = r_subnet[15:0]; end
      5'd8:  begin w_addr = 10'h018; w_wdata = r_ipv4[31:16]; end
      5'd9:  begin w_addr = 10'h01A; w_wdata = r_ipv4[15:0]; end
      5'd10: begin w_addr = 10'h020; w_wdata = TMS01R_VAL; end
      5'd11: begin w_addr = 10'h028; w_wdata = RMS01R_VAL; end
      5'd12: begin w_addr = 10'h030; w_wdata = MTYPER_VAL; end
      5'd13: begin w_addr = 10'h200; w_wdata = 16'h0002; end
      5'd14: begin w_addr = 10'h20A; w_wdata = SRC_PORT; end
      5'd15: begin w_addr = 10'h202; w_wdata = 16'h0001; end
      5'd16: begin w_we = 1'b0; w_addr = 10'h208; end
      default: begin w_we = 1'b0; end
    endcase
  end

  assign w5300_rst_n_o = (r_state != S_HW_RST);
  assign reg_req_o     = w_req;
  assign reg_we_o      = w_req && w_we;
  assign reg_addr_o    = w_req ? w_addr : 10'h000;
  assign reg_wdata_o   = (w_req && w_we) ? w_wdata : 16'h0000;
  assign busy_o        = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign done_o        = (r_state == S_DONE);
  assign error_o       = (r_state == S_ERROR);
  assign error_code_o  = r_err_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 32'd0;
      r_ack_cnt  <= 16'd0;
      r_poll_cnt <= 16'd0;
      r_step     <= STEP_IDR;
      r_mac      <= 48'd0;
      r_ipv4     <= 32'd0;
      r_subnet   <= 32'd0;
      r_gw_hi    <= 24'd0;
      r_err_code <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            r_mac      <= mac_i;
            r_ipv4     <= ipv4_i;
            r_subnet   <= subnet_i;
            r_gw_hi    <= ipv4_i[31:8];
            r_err_code <= 2'd0;
            r_cnt      <= 32'd0;
            r_step     <= STEP_IDR;
            r_poll_cnt <= 16'd0;
            r_state    <= S_HW_RST;
          end
        end
        S_HW_RST: begin
          if (r_cnt == HOLD_CYC - 32'd1) begin
            r_cnt   <= 32'd0;
            r_state <= S_HW_WAIT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_HW_WAIT: begin
          if (r_cnt == WAIT_CYC) begin
            r_ack_cnt <= 16'd0;
            r_state   <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_ISSUE, S_WAIT_ACK: begin
          // A zero-latency ack may arrive in the ISSUE cycle itself.
          if (w_ack) begin
            if (r_step == STEP_IDR && reg_rdata_i != 16'h5300) begin
              r_err_code <= ERR_ID;
              r_state    <= S_ERROR;
            end else if (r_step == STEP_SSR) begin
              if (reg_rdata_i[7:0] == 8'h22) begin
                r_state <= S_DONE;
              end else if (r_poll_cnt == POLL_MAX - 16'd1) begin
                r_err_code <= ERR_POLL;
                r_state    <= S_ERROR;
              end else begin
                r_poll_cnt <= r_poll_cnt + 16'd1;
                r_state    <= S_GAP;
              end
            end else begin
              r_step  <= r_step + 5'd1;
              r_state <= S_GAP;
            end
          end else if (r_ack_cnt == ACK_MAX - 16'd1) begin
            r_err_code <= ERR_ACK;
            r_state    <= S_ERROR;
          end else begin
            r_ack_cnt <= r_ack_cnt + 16'd1;
            r_state   <= S_WAIT_ACK;
          end
        end
        S_GAP: begin
          r_ack_cnt <= 16'd0;
          r_state   <= S_ISSUE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
